// File: rtl/rx_pkt_fetcher.sv
// Frames MAC receive words for the rx engine: status byte, running length, runt/oversize handling,
// repair of missing eop. Optional statistics counters are built when RX_FETCH_STAT_EN is defined.
module rx_pkt_fetcher #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] snk_data_i,
  input  logic        snk_valid_i,
  input  logic        snk_sop_i,
  input  logic        snk_eop_i,
  input  logic [2:0]  snk_empty_i,
  input  logic [2:0]  snk_error_i,
  output logic        snk_ready_o,
  output logic [63:0] data_o,
  output logic [7:0]  status_o,
  output logic [2:0]  error_o,
  output logic        en_o,
  output logic [15:0] pkt_len_o,
  input  logic        wr_full_i,
  output logic [31:0] stat_pkt_o,
  output logic [31:0] stat_drop_o,
  output logic [31:0] stat_err_o
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_PKT    = 2'd1;
  localparam logic [1:0]  ST_DROP   = 2'd2;
  localparam logic [1:0]  ST_INJECT = 2'd3;
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0]  state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s, base_s, sum_s, len_nxt_s;
  logic [3:0]  word_bytes_s;
  logic [2:0]  allowed_lo_s, trunc_empty_s, error_nxt_s;
  logic [7:0]  status_nxt_s;
  logic [63:0] data_nxt_s;
  logic        inject_pending_s, accept_s, emit_word_s, over_s, emit_s, len_upd_s;

  assign inject_pending_s = (state_r == ST_INJECT) ||
                            ((state_r == ST_PKT) && snk_valid_i && snk_sop_i);
  assign snk_ready_o  = rst_n_i && !wr_full_i && !inject_pending_s;
  assign accept_s     = snk_valid_i && snk_ready_o;
  assign emit_word_s  = accept_s && ((state_r == ST_PKT) || ((state_r == ST_IDLE) && snk_sop_i));
  assign base_s       = (state_r == ST_IDLE) ? 16'd0 : cnt_r;
  assign word_bytes_s = snk_eop_i ? (4'd8 - {1'b0, snk_empty_i}) : 4'd8;
  assign sum_s        = sat_add(base_s, word_bytes_s);
  assign over_s       = sum_s > MAX_LEN_W;
  // Bytes still allowed before MAX_LEN fit in 0..7; zero cannot be encoded, so it clamps to empty=7.
  assign allowed_lo_s  = MAX_LEN_W[2:0] - base_s[2:0];
  assign trunc_empty_s = (allowed_lo_s == 3'd0) ? 3'd7 : (3'd0 - allowed_lo_s);

  // Next-state and next-output selection for the framing FSM.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    emit_s       = 1'b0;
    data_nxt_s   = data_o;
    status_nxt_s = status_o;
    error_nxt_s  = error_o;
    len_upd_s    = 1'b0;
    len_nxt_s    = pkt_len_o;
    case (state_r)
      ST_IDLE, ST_PKT: begin
        if (emit_word_s) begin
          emit_s     = 1'b1;
          data_nxt_s = snk_data_i;
          if (over_s) begin
            status_nxt_s = {1'b0, 1'b1, 1'b0, trunc_empty_s, 1'b1, snk_sop_i};
            error_nxt_s  = snk_eop_i ? snk_error_i : 3'd0;
            len_upd_s    = 1'b1;
            len_nxt_s    = MAX_LEN_W;
            cnt_nxt_s    = 16'd0;
            state_nxt_s  = snk_eop_i ? ST_IDLE : ST_DROP;
          end else if (snk_eop_i) begin
            status_nxt_s = {1'b0, 1'b0, (sum_s < MIN_LEN_W), snk_empty_i, 1'b1, snk_sop_i};
            error_nxt_s  = snk_error_i;
            len_upd_s    = 1'b1;
            len_nxt_s    = sum_s;
            cnt_nxt_s    = 16'd0;
            state_nxt_s  = ST_IDLE;
          end else begin
            status_nxt_s = {7'd0, snk_sop_i};
            error_nxt_s  = 3'd0;
            cnt_nxt_s    = sum_s;
            state_nxt_s  = ST_PKT;
          end
        end else if (inject_pending_s) begin
          state_nxt_s = ST_INJECT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DROP: begin
        if (accept_s && snk_eop_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_INJECT: begin
        if (!wr_full_i) begin
          emit_s       = 1'b1;
          data_nxt_s   = 64'd0;
          status_nxt_s = {1'b0, 1'b0, (cnt_r < MIN_LEN_W), 3'd7, 1'b1, 1'b0};
          error_nxt_s  = 3'b100;
          len_upd_s    = 1'b1;
          len_nxt_s    = cnt_r;
          cnt_nxt_s    = 16'd0;
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s = ST_INJECT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, length counter and registered rx-engine outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      en_o      <= 1'b0;
      data_o    <= 64'd0;
      status_o  <= 8'd0;
      error_o   <= 3'd0;
      pkt_len_o <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      en_o    <= emit_s;
      if (emit_s) begin
        data_o   <= data_nxt_s;
        status_o <= status_nxt_s;
        error_o  <= error_nxt_s;
      end
      if (len_upd_s) begin
        pkt_len_o <= len_nxt_s;
      end
    end
  end

`ifdef RX_FETCH_STAT_EN
  logic [31:0] stat_pkt_r, stat_drop_r, stat_err_r;
  logic        eop_emit_s, drop_evt_s;

  assign eop_emit_s = emit_s && status_nxt_s[1];
  assign drop_evt_s = (accept_s && (state_r == ST_IDLE) && !snk_sop_i) || (emit_word_s && over_s);

  // Wrapping statistics counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_pkt_r  <= 32'd0;
      stat_drop_r <= 32'd0;
      stat_err_r  <= 32'd0;
    end else begin
      if (eop_emit_s) begin
        stat_pkt_r <= stat_pkt_r + 32'd1;
      end
      if (eop_emit_s && (error_nxt_s != 3'd0)) begin
        stat_err_r <= stat_err_r + 32'd1;
      end
      if (drop_evt_s) begin
        stat_drop_r <= stat_drop_r + 32'd1;
      end
    end
  end

  assign stat_pkt_o  = stat_pkt_r;
  assign stat_drop_o = stat_drop_r;
  assign stat_err_o  = stat_err_r;
`else
  assign stat_pkt_o  = 32'd0;
  assign stat_drop_o = 32'd0;
  assign stat_err_o  = 32'd0;
`endif

endmodule

// File: tb/tb_rx_pkt_fetcher.sv
// Directed bench for rx_pkt_fetcher: a packet-level model predicts the emitted word stream,
// a per-cycle monitor checks every write strobe against it, plus literal spot checks.
module tb_rx_pkt_fetcher;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [63:0] snk_data_i = 64'd0;
  logic        snk_valid_i = 1'b0, snk_sop_i = 1'b0, snk_eop_i = 1'b0;
  logic [2:0]  snk_empty_i = 3'd0, snk_error_i = 3'd0;
  logic        snk_ready_o, en_o;
  logic        wr_full_i = 1'b0;
  logic [63:0] data_o;
  logic [7:0]  status_o;
  logic [2:0]  error_o;
  logic [15:0] pkt_len_o;
  logic [31:0] stat_pkt_o, stat_drop_o, stat_err_o;

  rx_pkt_fetcher #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i), .snk_sop_i(snk_sop_i),
    .snk_eop_i(snk_eop_i), .snk_empty_i(snk_empty_i), .snk_error_i(snk_error_i),
    .snk_ready_o(snk_ready_o), .data_o(data_o), .status_o(status_o), .error_o(error_o),
    .en_o(en_o), .pkt_len_o(pkt_len_o), .wr_full_i(wr_full_i),
    .stat_pkt_o(stat_pkt_o), .stat_drop_o(stat_drop_o), .stat_err_o(stat_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [63:0] d; logic sop; logic eop; logic [2:0] emp; logic [2:0] err; } in_t;
  typedef struct { logic [63:0] d; logic [7:0] st; logic [2:0] er; logic [15:0] len; } word_t;

  in_t   stim[$];
  bit    emit_q[$];
  word_t exp_q[$];
  word_t got_q[$];
  word_t mon_a, mon_e;
  int    n_vec = 0, n_miss = 0;
  bit    m_in = 1'b0, m_drop = 1'b0;
  int    m_cnt = 0;
  int unsigned m_pkt = 0, m_dropc = 0, m_err = 0;
  bit    cur_emits = 1'b0, lat_pending = 1'b0;
  int    full_en_cnt = 0;

  // Spec-level model: one offered source word in, expected emitted words appended to exp_q.
  task automatic model_word(input in_t w, output bit emits);
    word_t o;
    int bytes, allowed;
    logic [2:0] emp3;
    emits = 1'b0;
    if (m_drop) begin
      if (w.eop) m_drop = 1'b0;
      return;
    end
    if (m_in && w.sop) begin
      o.d = 64'd0; o.er = 3'b100; o.len = 16'(m_cnt);
      o.st = {2'b00, (m_cnt < MIN_LEN), 3'd7, 1'b1, 1'b0};
      exp_q.push_back(o);
      m_pkt++; m_err++; m_in = 1'b0;
    end
    if (!m_in && !w.sop) begin
      m_dropc++;
      return;
    end
    if (!m_in) m_cnt = 0;
    emits = 1'b1;
    bytes = w.eop ? 8 - int'(w.emp) : 8;
    o.d = w.d; o.len = 16'd0;
    if (m_cnt + bytes > MAX_LEN) begin
      allowed = MAX_LEN - m_cnt;
      emp3 = 3'((allowed == 0) ? 7 : 8 - allowed);
      o.st = {1'b0, 1'b1, 1'b0, emp3, 1'b1, w.sop};
      o.er = w.eop ? w.err : 3'd0;
      o.len = 16'(MAX_LEN);
      m_pkt++; m_dropc++;
      if (o.er != 3'd0) m_err++;
      m_in = 1'b0; m_drop = !w.eop;
    end else if (w.eop) begin
      o.st = {1'b0, 1'b0, (m_cnt + bytes < MIN_LEN), w.emp, 1'b1, w.sop};
      o.er = w.err; o.len = 16'(m_cnt + bytes);
      m_pkt++;
      if (o.er != 3'd0) m_err++;
      m_in = 1'b0;
    end else begin
      o.st = {7'd0, w.sop}; o.er = 3'd0;
      m_cnt += bytes; m_in = 1'b1;
    end
    exp_q.push_back(o);
  endtask

  // Monitor: every write strobe is checked against the model, plus latency and backpressure.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (lat_pending) begin
        n_vec++;
        if (en_o !== 1'b1) begin n_miss++; $display("FAIL latency: en_o=%b required 1", en_o); end
      end
      if (en_o) begin
        mon_a.d = data_o; mon_a.st = status_o; mon_a.er = error_o; mon_a.len = pkt_len_o;
        got_q.push_back(mon_a);
        if (wr_full_i) full_en_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL spurious_en: got d=%h st=%h required no write", data_o, status_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a.d !== mon_e.d || mon_a.st !== mon_e.st || mon_a.er !== mon_e.er ||
              (mon_e.st[1] && mon_a.len !== mon_e.len)) begin
            n_miss++;
            $display("FAIL word: got d=%h st=%h er=%h len=%0d required d=%h st=%h er=%h len=%0d",
                     mon_a.d, mon_a.st, mon_a.er, mon_a.len, mon_e.d, mon_e.st, mon_e.er, mon_e.len);
          end
        end
      end
      if (wr_full_i) begin
        n_vec++;
        if (snk_ready_o !== 1'b0) begin n_miss++; $display("FAIL ready_under_full: got %b required 0", snk_ready_o); end
      end
      lat_pending = snk_valid_i && snk_ready_o && cur_emits;
    end else begin
      lat_pending = 1'b0;
    end
  end

  task automatic check_eq(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin n_miss++; $display("FAIL %s: got %0d required %0d", name, act, req); end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (en_o !== 1'b0 || data_o !== 64'd0 || status_o !== 8'd0 || error_o !== 3'd0 ||
        pkt_len_o !== 16'd0 || snk_ready_o !== 1'b0 || stat_pkt_o !== 32'd0 ||
        stat_drop_o !== 32'd0 || stat_err_o !== 32'd0) begin
      n_miss++;
      $display("FAIL %s: en=%b d=%h st=%h er=%h len=%0d rdy=%b stats=%0d/%0d/%0d required all 0",
               tag, en_o, data_o, status_o, error_o, pkt_len_o, snk_ready_o,
               stat_pkt_o, stat_drop_o, stat_err_o);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef RX_FETCH_STAT_EN
    check_eq({tag, "_stat_pkt"}, longint'(stat_pkt_o), longint'(m_pkt));
    check_eq({tag, "_stat_drop"}, longint'(stat_drop_o), longint'(m_dropc));
    check_eq({tag, "_stat_err"}, longint'(stat_err_o), longint'(m_err));
`else
    check_eq({tag, "_stat_pkt"}, longint'(stat_pkt_o), 0);
    check_eq({tag, "_stat_drop"}, longint'(stat_drop_o), 0);
    check_eq({tag, "_stat_err"}, longint'(stat_err_o), 0);
`endif
  endtask

  task automatic add(input logic [63:0] d, input logic sop, input logic eop,
                     input logic [2:0] emp, input logic [2:0] err);
    in_t w;
    w.d = d; w.sop = sop; w.eop = eop; w.emp = emp; w.err = err;
    stim.push_back(w);
  endtask

  task automatic drive_all();
    int  k;
    bit  ok;
    @(posedge clk_i); #1;
    for (int i = 0; i < stim.size(); i++) begin
      snk_data_i = stim[i].d; snk_sop_i = stim[i].sop; snk_eop_i = stim[i].eop;
      snk_empty_i = stim[i].emp; snk_error_i = stim[i].err; snk_valid_i = 1'b1;
      cur_emits = emit_q[i];
      k = 0; ok = 1'b0;
      while (!ok && k < 50) begin
        @(negedge clk_i); ok = snk_ready_o;
        @(posedge clk_i); #1; k++;
      end
      if (!ok) begin n_vec++; n_miss++; $display("FAIL accept_timeout: word %0d not accepted in 50 cycles", i); end
    end
    snk_valid_i = 1'b0; snk_sop_i = 1'b0; snk_eop_i = 1'b0; cur_emits = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin @(posedge clk_i); #1; k++; end
    repeat (2) begin @(posedge clk_i); #1; end
    check_eq("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic run_test();
    bit e;
    got_q.delete(); emit_q.delete(); full_en_cnt = 0;
    foreach (stim[i]) begin model_word(stim[i], e); emit_q.push_back(e); end
    drive_all();
    drain();
    stim.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 check_zero("reset");
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1'b1;

    // 1: 64-byte packet in 8 words, CRC error flag on eop
    for (int i = 0; i < 8; i++)
      add(64'h1111_0000_0000_0000 | 64'(i), i == 0, i == 7, 3'd0, (i == 7) ? 3'd1 : 3'd0);
    run_test();
    check_eq("t1_words", got_q.size(), 8);
    if (got_q.size() == 8) begin
      check_eq("t1_first_status", got_q[0].st, 8'h01);
      check_eq("t1_last_status", got_q[7].st, 8'h02);
      check_eq("t1_pkt_len", got_q[7].len, 64);
      check_eq("t1_error", got_q[7].er, 1);
    end
    check_stats("t1");

    // 2: single-word runt
    add(64'h2222_2222_2222_2222, 1'b1, 1'b1, 3'd2, 3'd0);
    run_test();
    check_eq("t2_words", got_q.size(), 1);
    check_eq("t2_status", status_o, 8'h2B);
    check_eq("t2_pkt_len", pkt_len_o, 6);

    // 3: backpressure for 3 cycles mid-packet
    for (int i = 0; i < 16; i++)
      add(64'h3333_0000_0000_0000 | 64'(i), i == 0, i == 15, 3'd0, 3'd0);
    fork
      run_test();
      begin
        repeat (5) @(posedge clk_i);
        #1 wr_full_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 wr_full_i = 1'b0;
      end
    join
    check_eq("t3_words", got_q.size(), 16);
    check_eq("t3_en_after_full_le1", longint'(full_en_cnt <= 1), 1);
    check_eq("t3_pkt_len", pkt_len_o, 128);

    // 4: oversize stream of 200 words
    for (int i = 0; i < 200; i++)
      add(64'h4444_0000_0000_0000 | 64'(i), i == 0, i == 199, 3'd0, 3'd0);
    run_test();
    check_eq("t4_words", got_q.size(), 190);
    if (got_q.size() == 190) begin
      check_eq("t4_trunc_status", got_q[189].st, 8'h4A);
      check_eq("t4_trunc_len", got_q[189].len, 1518);
      check_eq("t4_prev_status", got_q[188].st, 8'h00);
    end
`ifdef RX_FETCH_STAT_EN
    check_eq("t4_stat_drop_lit", longint'(stat_drop_o), 1);
`endif
    check_stats("t4");

    // 5: sop arrives at word 5 of an open packet
    for (int i = 0; i < 4; i++) add(64'h5555_0000_0000_0000 | 64'(i), i == 0, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) add(64'h5566_0000_0000_0000 | 64'(i), i == 0, i == 3, 3'd0, 3'd0);
    run_test();
    check_eq("t5_words", got_q.size(), 9);
    if (got_q.size() == 9) begin
      check_eq("t5_term_data", longint'(got_q[4].d), 0);
      check_eq("t5_term_error", got_q[4].er, 4);
      check_eq("t5_term_len", got_q[4].len, 32);
      check_eq("t5_term_status", got_q[4].st, 8'h3E);
      check_eq("t5_new_sop", got_q[5].st[0], 1);
      check_eq("t5_new_data", longint'(got_q[5].d), longint'(64'h5566_0000_0000_0000));
    end
    check_stats("t5");

    // 6: orphan words in IDLE
    for (int i = 0; i < 3; i++) add(64'h6666_0000_0000_0000 | 64'(i), 1'b0, i == 2, 3'd0, 3'd0);
    run_test();
    check_eq("t6_words", got_q.size(), 0);
    check_stats("t6");

    // 7: reset in the middle of a packet
    for (int i = 0; i < 3; i++) add(64'h7777_0000_0000_0000 | 64'(i), i == 0, 1'b0, 3'd0, 3'd0);
    run_test();
    #3 rst_n_i = 1'b0;
    #1 check_zero("reset_mid_packet");
    m_in = 1'b0; m_drop = 1'b0; m_cnt = 0; m_pkt = 0; m_dropc = 0; m_err = 0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1'b1;

    // 8: clean single-word packet after reset
    add(64'h8888_8888_8888_8888, 1'b1, 1'b1, 3'd0, 3'd2);
    run_test();
    check_eq("t8_status", status_o, 8'h23);
    check_eq("t8_pkt_len", pkt_len_o, 8);
    check_stats("t8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
